dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port data memory (`DataMemory`) of the RISC-V unicycle core. Port 0 is the core load/store path; port 1 is the program/data loader and debug path, used for preloading memory and for inspection.
The block serialises requests and drives the memory's `write_enable`/`read_enable`/`address`/`write_data` for a fixed number of cycles. It returns read data with a one-cycle acknowledge.
It is the only master of the data memory. The core stalls on its port while `p0_ack` is pending.

---
 rtl/dmem_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-port arbiter and sequencer in front of the single-port DataMemory of
//   the unicycle core. It serialises requests from the core load/store path
//   (port 0) and the loader/debug path (port 1). For each request it drives the
//   memory command for MEM_LAT cycles and returns read data with a one-cycle ack.
//
//   Optional feature macro: DMEM_ARB_RR_EN
//     defined   -> ties are broken round-robin using a last_grant register
//     undefined -> port 0 always wins ties, and no last_grant register is built
//
// Ports
//   clock, rst                     rising-edge clock, async active-high reset
//   pN_req/pN_we/pN_addr/pN_wdata  request side of port N (N = 0, 1)
//   pN_gnt                         port N owns the memory (ACCESS and RESP)
//   pN_ack                         one-cycle completion pulse for port N
//   pN_rdata                       last read data of port N, held until the next read
//   mem_we/mem_re/mem_addr/
//   mem_wdata                      command to DataMemory
//   mem_rdata                      read data from DataMemory
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  state_t            state_q,     state_d;
  logic              owner_q,     owner_d;
  logic [3:0]        cnt_q,       cnt_d;
  logic              cmd_we_q,    cmd_we_d;
  logic [DATA_W-1:0] p0_rdata_q,  p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q,  p1_rdata_d;
  logic              p0_gnt_q,    p0_gnt_d;
  logic              p1_gnt_q,    p1_gnt_d;
  logic              p0_ack_q,    p0_ack_d;
  logic              p1_ack_q,    p1_ack_d;
  logic              mem_we_q,    mem_we_d;
  logic              mem_re_q,    mem_re_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              win_s;       // 0 = port 0 wins, 1 = port 1 wins
  logic              win_we_s;

`ifdef DMEM_ARB_RR_EN
  logic              last_grant_q, last_grant_d;

  // Winner selection: on a tie the port that was not served last wins.
  always_comb begin
    win_s = 1'b0;
    if (p0_req && p1_req) begin
      win_s = ~last_grant_q;
    end else begin
      win_s = ~p0_req;
    end
  end

  // last_grant register; reset to 1 so port 0 wins the first tie.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Winner selection: fixed priority, port 0 wins whenever it requests.
  always_comb begin
    win_s = ~p0_req;
  end
`endif

  assign win_we_s = win_s ? p1_we : p0_we;

  // Next-state and next-output logic. The outputs are registered, so each
  // output is computed for the state being entered.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    cmd_we_d    = cmd_we_q;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    p0_gnt_d    = 1'b0;
    p1_gnt_d    = 1'b0;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef DMEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (p0_req || p1_req) begin
          state_d     = ST_ACCESS;
          owner_d     = win_s;
          cnt_d       = CNT_LOAD;
          cmd_we_d    = win_we_s;
          mem_addr_d  = win_s ? p1_addr  : p0_addr;
          mem_wdata_d = win_s ? p1_wdata : p0_wdata;
          // The write strobe is raised only for the first ACCESS cycle.
          mem_we_d    = win_we_s;
          mem_re_d    = ~win_we_s;
          p0_gnt_d    = ~win_s;
          p1_gnt_d    = win_s;
        end else begin
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end
      ST_ACCESS: begin
        p0_gnt_d = ~owner_q;
        p1_gnt_d = owner_q;
        if (cnt_q == 4'd0) begin
          // Last ACCESS cycle: mem_rdata is valid now.
          if (!cmd_we_q) begin
            if (owner_q) begin
              p1_rdata_d = mem_rdata;
            end else begin
              p0_rdata_d = mem_rdata;
            end
          end else begin
            p0_rdata_d = p0_rdata_q;
          end
          state_d     = ST_RESP;
          p0_ack_d    = ~owner_q;
          p1_ack_d    = owner_q;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end else begin
          cnt_d    = cnt_q - 4'd1;
          mem_re_d = ~cmd_we_q;
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
`ifdef DMEM_ARB_RR_EN
        last_grant_d = owner_q;
`endif
      end
      default: begin
        state_d     = ST_IDLE;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
    endcase
  end

  // State, command and output registers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= 4'd0;
      cmd_we_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      p0_gnt_q    <= 1'b0;
      p1_gnt_q    <= 1'b0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      cmd_we_q    <= cmd_we_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_gnt_q    <= p0_gnt_d;
      p1_gnt_q    <= p1_gnt_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign p0_gnt    = p0_gnt_q;
  assign p1_gnt    = p1_gnt_q;
  assign p0_ack    = p0_ack_q;
  assign p1_ack    = p1_ack_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_ack, p1_gnt, p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // second instance with MEM_LAT = 3, port 1 unused
  logic        q_req;
  logic [31:0] q_addr;
  logic        q_gnt, q_ack, q1_gnt, q1_ack;
  logic [31:0] q_rdata, q1_rdata;
  logic        mem_we3, mem_re3;
  logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut (
    .clock(clock), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_lat3 (
    .clock(clock), .rst(rst),
    .p0_req(q_req), .p0_we(1'b0), .p0_addr(q_addr), .p0_wdata(32'h0),
    .p0_gnt(q_gnt), .p0_ack(q_ack), .p0_rdata(q_rdata),
    .p1_req(1'b0), .p1_we(1'b0), .p1_addr(32'h0), .p1_wdata(32'h0),
    .p1_gnt(q1_gnt), .p1_ack(q1_ack), .p1_rdata(q1_rdata),
    .mem_we(mem_we3), .mem_re(mem_re3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  // Memory model for the MEM_LAT=1 instance: combinational read, write on edge.
  logic [31:0] mem [0:63];
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[7:2]];

  // Slow memory model: data becomes valid only in the third mem_re cycle.
  int re_cnt3 = 0;
  always @(posedge clock) begin
    re_cnt3 <= mem_re3 ? re_cnt3 + 1 : 0;
  end
  assign mem_rdata3 = (re_cnt3 >= 2) ? (32'h3300_0000 | mem_addr3) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_excl();
    chk("excl_gnt", {31'd0, p0_gnt & p1_gnt}, 32'd0);
    chk("excl_ack", {31'd0, p0_ack & p1_ack}, 32'd0);
    chk("excl_we_re", {31'd0, mem_we & mem_re}, 32'd0);
  endtask

  // One transaction on the MEM_LAT=1 instance; entered and left at a negedge
  // while the arbiter is idle.
  task automatic txn(input int port, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input string tag);
    int n = 0;
    int re_cyc = 0;
    int we_cyc = 0;
    logic got = 1'b0;
    if (port == 0) begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
    while (!got && n < 20) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (n == 1) chk({tag, "_gnt"}, {31'd0, (port == 0) ? p0_gnt : p1_gnt}, 32'd1);
      if (mem_re) re_cyc++;
      if (mem_we) begin
        we_cyc++;
        chk({tag, "_we_addr"}, mem_addr, addr);
        chk({tag, "_we_data"}, mem_wdata, wdata);
      end
      chk_excl();
      got = (port == 0) ? p0_ack : p1_ack;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    chk({tag, "_ack_lat"}, n, 32'd2);
    chk({tag, "_re_cycles"}, re_cyc, we ? 32'd0 : 32'd1);
    chk({tag, "_we_cycles"}, we_cyc, we ? 32'd1 : 32'd0);
    chk({tag, "_rdata"}, (port == 0) ? p0_rdata : p1_rdata, exp_rdata);
    @(posedge clock);
    @(negedge clock);
  endtask

  int n_ack;
  int ord [4];
  int exp_port;

  initial begin
    rst = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
    q_req = 1'b0; q_addr = 32'h0;
    repeat (3) @(negedge clock);
    chk("rst_p0_gnt", {31'd0, p0_gnt}, 32'd0);
    chk("rst_p0_ack", {31'd0, p0_ack}, 32'd0);
    chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_p1_rdata", p1_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clock);

    // preload and single reads
    txn(1, 1'b1, 32'h10, 32'h0000_00AA, 32'h0, "p1_wr10");
    txn(0, 1'b0, 32'h10, 32'h0, 32'h0000_00AA, "p0_rd10");
    txn(1, 1'b0, 32'h10, 32'h0, 32'h0000_00AA, "p1_rd10");
    // write keeps p1_rdata, read-back returns the written word
    txn(1, 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h0000_00AA, "p1_wr20");
    txn(1, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, "p1_rd20");
    chk("p0_rdata_held", p0_rdata, 32'h0000_00AA);

    // MEM_LAT = 3 read on the second instance
    begin
      int n = 0;
      int re_cyc = 0;
      logic got = 1'b0;
      q_req = 1'b1; q_addr = 32'h44;
      while (!got && n < 20) begin
        @(posedge clock);
        n++;
        @(negedge clock);
        if (mem_re3) re_cyc++;
        got = q_ack;
      end
      q_req = 1'b0;
      chk("lat3_ack_lat", n, 32'd4);
      chk("lat3_re_cycles", re_cyc, 32'd3);
      chk("lat3_rdata", q_rdata, 32'h3300_0044);
      @(posedge clock);
      @(negedge clock);
    end

    // request withdrawal one cycle after grant
    begin
      int n = 0;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h20;
      @(posedge clock);
      @(negedge clock);
      chk("wd_gnt", {31'd0, p0_gnt}, 32'd1);
      p0_req = 1'b0;
      n_ack = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clock);
        @(negedge clock);
        if (p0_ack) n_ack++;
        chk_excl();
      end
      chk("wd_ack_count", n_ack, 32'd1);
      chk("wd_rdata", p0_rdata, 32'hDEAD_BEEF);
      chk("wd_idle_gnt", {31'd0, p0_gnt}, 32'd0);
      n = n_ack;
    end

    // simultaneous requests held for 4 transactions, starting from reset state
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h20;
    n_ack = 0;
    for (int i = 0; i < 40 && n_ack < 4; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk_excl();
      if (p0_ack || p1_ack) begin
        ord[n_ack] = p1_ack ? 1 : 0;
        n_ack++;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    chk("tie_ack_count", n_ack, 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_port = i % 2;
`else
      exp_port = 0;
`endif
      if (i < n_ack) chk($sformatf("tie_order_%0d", i), ord[i], exp_port);
    end
    @(posedge clock);
    @(negedge clock);

    // reset during ACCESS of a read
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    @(posedge clock);
    @(negedge clock);
    chk("rstacc_gnt_before", {31'd0, p0_gnt}, 32'd1);
    chk("rstacc_re_before", {31'd0, mem_re}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstacc_gnt", {31'd0, p0_gnt}, 32'd0);
    chk("rstacc_re", {31'd0, mem_re}, 32'd0);
    chk("rstacc_addr", mem_addr, 32'd0);
    chk("rstacc_rdata", p0_rdata, 32'd0);
    p0_req = 1'b0;
    @(negedge clock);
    rst = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (p0_ack || p1_ack) n_ack++;
    end
    chk("rstacc_no_ack", n_ack, 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 32'h0000_00AA, "post_rst_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
